// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline front end.
//   NOP_INSTR         instruction word presented when no real instruction is
//                     held (sll $0,$0,0)
//   DEFAULT_RESET_PC  PC loaded on reset unless overridden by the instantiator
//   fetch_state_t     fetch controller states
//   fetch_out_t       {pc_plus4, instr} payload carried to the IF/ID register
//   pc_inc()          PC + 4, wrapping mod 2^32
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,   // request outstanding at pc
      BLOCKED = 2'd1,   // skid full, no request
      KILL    = 2'd2,   // request outstanding at a stale address, result dropped
      EXC     = 2'd3    // misaligned target, no requests until next redirect
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc_plus4;
      logic [31:0] instr;
   } fetch_out_t;

   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_if
// Instruction-memory request/acknowledge bus.
//   imem_req    fetch request, held until imem_ack
//   imem_addr   fetch address, stable while imem_req=1
//   imem_ack    request complete; imem_rdata valid in the same cycle
//   imem_rdata  fetched instruction
// Modports: master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface if_fetch_stage_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/if_skid_buf.sv
// -----------------------------------------------------------------------------
// if_skid_buf
// One-entry holding buffer for a fetched {pc_plus4, instr} that returns while
// the IF/ID register is stalled.
//   clk, rst    clock, asynchronous active-high reset (clears valid only)
//   load        capture load_data, buffer becomes valid
//   load_data   payload to capture
//   drain       buffer contents consumed, buffer becomes empty
//   flush       discard contents (wins over load and drain)
//   valid       buffer holds an entry
//   data        buffered payload
// -----------------------------------------------------------------------------
module if_skid_buf
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  fetch_out_t load_data,
   input  logic       drain,
   input  logic       flush,
   output logic       valid,
   output fetch_out_t data
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        valid <= 1'b0;
      else if (flush) valid <= 1'b0;
      else if (load)  valid <= 1'b1;
      else if (drain) valid <= 1'b0;
   end

   // Payload needs no reset: it is only observed while valid is set.
   always_ff @(posedge clk) begin
      if (load && !flush) data <= load_data;
   end

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, fetches
// over a req/ack bus and presents {PC+4, instruction} with a valid flag to the
// IF/ID register. A one-entry skid buffer absorbs an instruction returning
// while ID is stalled. Redirects flush the stage; a request already in flight
// is allowed to complete at its original address and its data is dropped.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   stall         ID cannot accept; hold current output
//   redirect      branch/jump taken; flush and reload PC
//   redirect_pc   new PC, valid with redirect
//   imem          instruction-memory bus (master side)
//   if_valid      output holds a real instruction
//   if_pc_plus4   PC+4 of presented instruction
//   if_instr      presented instruction (NOP_INSTR when if_valid=0)
//   if_exc        misaligned-fetch flag (only with IF_MISALIGN_CHECK_EN)
//
// Build option: define IF_MISALIGN_CHECK_EN to trap redirects to non-word-
// aligned targets; otherwise redirect_pc[1:0] is forced to 2'b00.
// -----------------------------------------------------------------------------
module if_fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    stall,
   input  logic                    redirect,
   input  logic [31:0]             redirect_pc,
   if_fetch_stage_if.master        imem,
   output logic                    if_valid,
   output logic [31:0]             if_pc_plus4,
   output logic [31:0]             if_instr
`ifdef IF_MISALIGN_CHECK_EN
   ,
   output logic                    if_exc
`endif
);

   fetch_state_t state, state_n;
   logic [31:0]  pc, pc_n;
   logic [31:0]  kill_addr, kill_addr_n;   // address of the request being killed
   logic         valid_n;
   logic [31:0]  pc4_n, instr_n;
   logic         slot_free, drains;
   logic [31:0]  target_pc;
   logic         target_mis, pc_mis;

   logic         skid_load, skid_drain, skid_flush, skid_valid;
   fetch_out_t   skid_in, skid_data;

`ifdef IF_MISALIGN_CHECK_EN
   logic exc_n, exc_sent, exc_sent_n;   // exc_sent: trap already presented
   assign target_pc  = redirect_pc;
   assign target_mis = |redirect_pc[1:0];
   assign pc_mis     = |pc[1:0];
`else
   assign target_pc  = redirect_pc & ~32'h3;
   assign target_mis = 1'b0;
   assign pc_mis     = 1'b0;
`endif

   assign drains    = if_valid && !stall;
   assign slot_free = !if_valid || !stall;

   // Requests are suppressed combinationally during reset so memory sees none.
   assign imem.imem_req  = !rst && (state == FETCH || state == KILL);
   assign imem.imem_addr = (state == KILL) ? kill_addr : pc;

   assign skid_in = {pc_inc(pc), imem.imem_rdata};

   if_skid_buf u_skid (
      .clk       (clk),
      .rst       (rst),
      .load      (skid_load),
      .load_data (skid_in),
      .drain     (skid_drain),
      .flush     (skid_flush),
      .valid     (skid_valid),
      .data      (skid_data)
   );

   always_comb begin
      state_n     = state;
      pc_n        = pc;
      kill_addr_n = kill_addr;
      valid_n     = if_valid;
      pc4_n       = if_pc_plus4;
      instr_n     = if_instr;
      skid_load   = 1'b0;
      skid_drain  = 1'b0;
      skid_flush  = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      exc_n       = if_exc;
      exc_sent_n  = exc_sent;
`endif

      if (drains) begin
         valid_n = 1'b0;
         instr_n = NOP_INSTR;
`ifdef IF_MISALIGN_CHECK_EN
         exc_n   = 1'b0;
`endif
      end

      if (redirect) begin
         valid_n    = 1'b0;
         instr_n    = NOP_INSTR;
         skid_flush = 1'b1;
         pc_n       = target_pc;
`ifdef IF_MISALIGN_CHECK_EN
         exc_n      = 1'b0;
         exc_sent_n = 1'b0;
`endif
         unique case (state)
            FETCH: begin
               if (imem.imem_ack) begin
                  state_n = target_mis ? EXC : FETCH;
               end else begin
                  // Keep the in-flight address on the bus until it acks.
                  state_n     = KILL;
                  kill_addr_n = pc;
               end
            end
            KILL: begin
               if (imem.imem_ack) state_n = target_mis ? EXC : FETCH;
            end
            default: state_n = target_mis ? EXC : FETCH;
         endcase
      end else begin
         unique case (state)
            FETCH: begin
               if (imem.imem_ack) begin
                  pc_n = pc_inc(pc);
                  if (slot_free) begin
                     valid_n = 1'b1;
                     pc4_n   = pc_inc(pc);
                     instr_n = imem.imem_rdata;
                  end else begin
                     skid_load = 1'b1;
                     state_n   = BLOCKED;
                  end
               end
            end
            BLOCKED: begin
               if (slot_free) begin
                  valid_n          = 1'b1;
                  {pc4_n, instr_n} = skid_data;
                  skid_drain       = 1'b1;
                  state_n          = FETCH;
               end
            end
            KILL: begin
               if (imem.imem_ack) state_n = pc_mis ? EXC : FETCH;
            end
            default: begin
`ifdef IF_MISALIGN_CHECK_EN
               // Present the trap once; it then drains like any instruction.
               if (slot_free && !exc_sent) begin
                  valid_n    = 1'b1;
                  pc4_n      = pc_inc(pc);
                  instr_n    = NOP_INSTR;
                  exc_n      = 1'b1;
                  exc_sent_n = 1'b1;
               end
`endif
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         if_valid    <= 1'b0;
         if_pc_plus4 <= 32'h0;
         if_instr    <= NOP_INSTR;
`ifdef IF_MISALIGN_CHECK_EN
         if_exc      <= 1'b0;
         exc_sent    <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         if_valid    <= valid_n;
         if_pc_plus4 <= pc4_n;
         if_instr    <= instr_n;
`ifdef IF_MISALIGN_CHECK_EN
         if_exc      <= exc_n;
         exc_sent    <= exc_sent_n;
`endif
      end
   end

   always_ff @(posedge clk) begin
      kill_addr <= kill_addr_n;
   end

endmodule
